// File: rtl/display_scan_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; entry k is hex digit k.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // GAP is the one-cycle dead time between digits that suppresses ghosting.
    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/display_scan_if.sv
// Bundle of data-load, control and display-drive signals for display_scan.
// Latency: n/a (wiring only).
// Backpressure: none; load is accepted on every edge it is high.
// Ports: load/value/lz_en from the host side, seg/dig_sel towards the display.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    lz_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;

    modport master (
        output load, value, lz_en,
        input  seg, dig_sel
    );

    modport slave (
        input  load, value, lz_en,
        output seg, dig_sel
    );
endinterface

// File: rtl/display_scan_seg_decode.sv
// Hex nibble to active-low 7-segment pattern lookup.
// Latency: combinational.
// Backpressure: none.
// Ports: hex (4-bit digit in), seg (7-bit {g,f,e,d,c,b,a}, 0 = lit).
module seg_decode
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed hex display driver: one gap cycle then REFRESH_DIV-1 drive cycles per digit.
// Latency: outputs registered; a load or lz_en change shows on the cycle after the sampling edge.
// Backpressure: none; load is always accepted.
// Ports: clk, rst_n (async active-low), bus (slave side: load/value/lz_en in, seg/dig_sel out).
module display_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    display_scan_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] disp, disp_nxt;
    logic                    tick;

    logic [4*NUM_DIGITS-1:0] disp_shift;
    logic                    lz_blank;
    logic [6:0]              nib_seg;
    logic [6:0]              seg_nxt, seg_q;
    logic [NUM_DIGITS-1:0]   dig_sel_nxt, dig_sel_q;

    // Prescaler: free-running, wraps at REFRESH_DIV-1 and flags the digit boundary.
    assign tick    = (cnt == CNT_LAST);
    assign cnt_nxt = tick ? '0 : cnt + CNT_W'(1);

    assign disp_nxt = bus.load ? bus.value : disp;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            GAP: begin
                state_nxt = DRIVE;
            end
            DRIVE: begin
                if (tick) begin
                    state_nxt = GAP;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: begin
                state_nxt = GAP;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they always agree with
    // the state, index and display register that are current after the edge.
    assign disp_shift = disp_nxt >> {idx_nxt, 2'b00};

    // Leading digit is blank when it and everything above it is zero; digit 0 always shows.
    assign lz_blank = bus.lz_en && (idx_nxt != '0) && (disp_shift == '0);

    seg_decode u_seg_decode (
        .hex (disp_shift[3:0]),
        .seg (nib_seg)
    );

    always_comb begin
        seg_nxt = SEG_BLANK;
        if (state_nxt == DRIVE && !lz_blank) begin
            seg_nxt = nib_seg;
        end
    end

    always_comb begin
        dig_sel_nxt = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (state_nxt == DRIVE && idx_nxt == IDX_W'(k)) begin
                dig_sel_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GAP;
            cnt       <= '0;
            idx       <= '0;
            disp      <= '0;
            seg_q     <= SEG_BLANK;
            dig_sel_q <= '1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            disp      <= disp_nxt;
            seg_q     <= seg_nxt;
            dig_sel_q <= dig_sel_nxt;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_sel_q;

endmodule
